median_window_ctrl: RTL and testbench
=====================================

Name: median_window_ctrl

Overview:
- Sequencing controller for the per-channel 3x3 median datapath in the VGA path (vga_clk domain).
- Tracks VGA scan coordinates and rotates three line-buffer banks.
- Generates line-buffer write/read addressing, window-valid and border flags, and coordinate tags aligned to the median pipeline latency.
- Latches the filter/bypass mode only at frame boundaries, so one frame is never mixed-mode.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
PIPE_LAT, 3, cycles from window presentation to median result (comparator tree depth)
ADDR_W, 10, line-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE

Ports:
vga_clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pixel_x  in  10  current scan column from VGA timing; active when < H_ACTIVE
pixel_y  in  10  current scan row; active when < V_ACTIVE
filt_en_req  in  1  filter enable request (switch/register); sampled at frame start only
lb_wr_en  out  1  write current pixel into bank wr_bank
lb_addr  out  ADDR_W  shared write/read address (= pixel_x)
wr_bank  out  2  bank being written (0..2)
rd_bank_top  out  2  bank holding line y-2
rd_bank_mid  out  2  bank holding line y-1
win_valid  out  1  3x3 window at datapath input is complete
win_border  out  1  window centre lies on column 0
out_valid  out  1  median result valid (win_valid delayed PIPE_LAT)
out_sel  out  1  1 = filtered result, 0 = bypass centre pixel
out_x  out  10  centre column of the current result
out_y  out  10  centre row of the current result
frame_start  out  1  one-cycle pulse at the first active pixel of a frame
state  out  2  0 IDLE, 1 PRIME, 2 RUN (debug)

Behaviour:
- Reset (async, rst_n=0): every output 0; state=IDLE; wr_bank=0; filt_en=0; lines_loaded=0; delay line cleared.
- active = (pixel_x < H_ACTIVE) && (pixel_y < V_ACTIVE).
- line_end = active && pixel_x == H_ACTIVE-1.
- fs (frame start) = pixel_x==0 && pixel_y==0 && the previous cycle's coordinates were not (0,0); registered into frame_start.
- On fs:
  - filt_en <= filt_en_req;
  - wr_bank <= 0; lines_loaded <= 0;
  - state <= PRIME, from any state.
  - A premature fs while in PRIME/RUN restarts PRIME cleanly (timing glitch recovery).
- Line-buffer control:
  - lb_wr_en = active in PRIME or RUN; lb_addr = pixel_x.
  - rd_bank_top = (wr_bank+1) mod 3; rd_bank_mid = (wr_bank+2) mod 3.
- On line_end: wr_bank advances 0->1->2->0. The new value is visible the cycle after the last pixel of the line.
- FSM:
  - IDLE -> PRIME on fs.
  - PRIME: lines_loaded increments on line_end; at the line_end where lines_loaded==1, go to RUN (two lines buffered).
  - RUN -> IDLE on line_end with pixel_y==V_ACTIVE-1.
  - fs has priority over line_end when both occur in the same cycle.
- Window:
  - win_valid = RUN && active && pixel_x >= 1, registered.
  - The window's rightmost column is pixel_x; the centre is (pixel_x-1, pixel_y-1).
  - win_border = win_valid && centre column == 0.
  - Centre rows cover 1..V_ACTIVE-2 and centre columns 0..H_ACTIVE-2; row 0 and the last row/column are not emitted.
- Output alignment:
  - out_valid, out_x, out_y and border are delayed PIPE_LAT cycles through a shift register.
  - out_sel = out_valid && filt_en && !border_delayed; 0 otherwise.
- Per frame there are exactly (V_ACTIVE-2)*(H_ACTIVE-1) out_valid cycles.
- Blanking: lb_wr_en=0 and win_valid=0. Counters and banks hold.
- filt_en_req changes mid-frame have no effect until the next fs.
- Reset asserted mid-frame aborts immediately. After release, the block waits in IDLE for the next fs; it never resumes mid-frame.

Decomposition:
- Shared package (median_pkg):
  - state encodings IDLE/PRIME/RUN;
  - NUM_BANKS=3;
  - default H_ACTIVE/V_ACTIVE;
  - PIPE_LAT constant, shared with the median single-colour datapath so latency stays consistent.
- One natural sub-module: median_tag_delay, a PIPE_LAT-deep shift register carrying {valid, border, x, y}.

Test Plan:
1. H_ACTIVE=8, V_ACTIVE=6, PIPE_LAT=3, full frame scan -> exactly 4*7=28 out_valid pulses; first result out_x=0, out_y=1, out_sel=0 (border); second result out_x=1, out_sel=1.
2. Bank rotation: across 4 consecutive lines -> wr_bank sequence 0,1,2,0, changing the cycle after pixel_x=7; rd_bank_top/rd_bank_mid = (1,2),(2,0),(0,1),(1,2).
3. filt_en_req toggled 1->0 at pixel_y=3 -> out_sel stays 1 on non-border results for the rest of the frame; all out_sel=0 in the next frame.
4. Premature fs injected at pixel_y=3 while in RUN -> state=PRIME next cycle, wr_bank=0, no win_valid until two further lines are buffered.
5. rst_n pulsed low at pixel_y=2, pixel_x=4 -> all outputs 0 asynchronously; after release no out_valid until the next frame's third line + PIPE_LAT.
6. Default 640x480 frame -> 305442 out_valid pulses; frame_start is a single-cycle pulse per frame.

Source files
------------

// File: rtl/median_pkg.sv
// ============================================================================
// Module      : median_pkg
// Description : Shared types and constants for the 3x3 median window path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package median_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int NUM_BANKS    = 3;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  // Comparator-tree depth of the single-colour median datapath.
  localparam int PIPE_LAT_DEF = 3;

  function automatic logic [1:0] bank_add(input logic [1:0] b, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, b} + {1'b0, k};
    if (s >= 3'(NUM_BANKS)) s = s - 3'(NUM_BANKS);
    return s[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/median_tag_delay.sv
// ============================================================================
// Module      : median_tag_delay
// Description : DEPTH-stage shift register carrying window tags alongside the
//               median pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_tag_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 22
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tag_o
);

  generate
    if (DEPTH == 0) begin : g_passthru
      assign tag_o = tag_i;
    end else begin : g_shift
      logic [W-1:0] pipe_q [DEPTH];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= tag_i;
          for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign tag_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/median_window_ctrl.sv
// ============================================================================
// Module      : median_window_ctrl
// Description : Scan tracking, line-buffer bank rotation and window/result
//               tagging for the 3x3 median filter in the VGA pixel domain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_window_ctrl
  import median_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int ADDR_W   = 10
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              filt_en_req,
  output logic              lb_wr_en,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank_top,
  output logic [1:0]        rd_bank_mid,
  output logic              win_valid,
  output logic              win_border,
  output logic              out_valid,
  output logic              out_sel,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic              frame_start,
  output logic [1:0]        state
);

  localparam logic [9:0] H_MAX  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_MAX  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);
  localparam int         TAG_W  = 22;

  state_e     state_q, state_d;
  logic [1:0] wr_bank_q, wr_bank_d;
  logic       loaded_q, loaded_d;
  logic       filt_en_q, filt_en_d;
  logic       prev_origin_q;
  logic       frame_start_q;
  logic       win_valid_q, win_border_q;
  logic [9:0] win_x_q, win_y_q;

  logic             w_active, w_line_end, w_origin, w_fs, w_win, w_busy;
  logic [TAG_W-1:0] w_tag_in, w_tag_out;

  assign w_active   = (pixel_x < H_MAX) && (pixel_y < V_MAX);
  assign w_line_end = w_active && (pixel_x == H_LAST);
  assign w_origin   = (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign w_fs       = w_origin && !prev_origin_q;
  assign w_busy     = (state_q != ST_IDLE);
  assign w_win      = (state_q == ST_RUN) && w_active && (pixel_x != 10'd0);

  // Frame start outranks line end; a glitched restart re-primes from scratch.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    loaded_d  = loaded_q;
    filt_en_d = filt_en_q;
    if (w_fs) begin
      state_d   = ST_PRIME;
      wr_bank_d = 2'd0;
      loaded_d  = 1'b0;
      filt_en_d = filt_en_req;
    end else if (w_line_end) begin
      case (state_q)
        ST_PRIME: begin
          wr_bank_d = bank_add(wr_bank_q, 2'd1);
          loaded_d  = 1'b1;
          if (loaded_q) state_d = ST_RUN;
        end
        ST_RUN: begin
          wr_bank_d = bank_add(wr_bank_q, 2'd1);
          if (pixel_y == V_LAST) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 2'd0;
      loaded_q      <= 1'b0;
      filt_en_q     <= 1'b0;
      prev_origin_q <= 1'b0;
      frame_start_q <= 1'b0;
      win_valid_q   <= 1'b0;
      win_border_q  <= 1'b0;
      win_x_q       <= 10'd0;
      win_y_q       <= 10'd0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      loaded_q      <= loaded_d;
      filt_en_q     <= filt_en_d;
      prev_origin_q <= w_origin;
      frame_start_q <= w_fs;
      win_valid_q   <= w_win;
      win_border_q  <= w_win && (pixel_x == 10'd1);
      win_x_q       <= w_win ? pixel_x - 10'd1 : 10'd0;
      win_y_q       <= w_win ? pixel_y - 10'd1 : 10'd0;
    end
  end

  // Read banks are meaningless while idle and are held at zero there.
  assign lb_wr_en    = w_active && w_busy;
  assign lb_addr     = lb_wr_en ? ADDR_W'(pixel_x) : '0;
  assign wr_bank     = wr_bank_q;
  assign rd_bank_top = w_busy ? bank_add(wr_bank_q, 2'd1) : 2'd0;
  assign rd_bank_mid = w_busy ? bank_add(wr_bank_q, 2'd2) : 2'd0;
  assign win_valid   = win_valid_q;
  assign win_border  = win_border_q;
  assign frame_start = frame_start_q;
  assign state       = state_q;

  assign w_tag_in = {win_valid_q, win_border_q, win_x_q, win_y_q};

  median_tag_delay #(
    .DEPTH (PIPE_LAT),
    .W     (TAG_W)
  ) u_tag_delay (
    .clk_i  (vga_clk),
    .rst_ni (rst_n),
    .tag_i  (w_tag_in),
    .tag_o  (w_tag_out)
  );

  assign out_valid = w_tag_out[21];
  assign out_sel   = w_tag_out[21] && filt_en_q && !w_tag_out[20];
  assign out_x     = w_tag_out[19:10];
  assign out_y     = w_tag_out[9:0];

endmodule

`default_nettype wire

// File: tb/tb_median_window_ctrl.sv
// ============================================================================
// Module      : tb_median_window_ctrl
// Description : Randomized scan stimulus against a scoreboard reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_median_window_ctrl;
  import median_pkg::*;

  localparam int H      = 8;
  localparam int V      = 6;
  localparam int LAT    = PIPE_LAT_DEF;
  localparam int ADDR_W = 10;
  localparam int V_TOT  = V + 2;
  localparam int N_OUT  = (V - 2) * (H - 1);

  logic              vga_clk = 1'b0;
  logic              rst_n;
  logic [9:0]        pixel_x, pixel_y;
  logic              filt_en_req;
  logic              lb_wr_en;
  logic [ADDR_W-1:0] lb_addr;
  logic [1:0]        wr_bank, rd_bank_top, rd_bank_mid, state;
  logic              win_valid, win_border, out_valid, out_sel, frame_start;
  logic [9:0]        out_x, out_y;

  always #5 vga_clk = ~vga_clk;

  median_window_ctrl #(
    .H_ACTIVE (H), .V_ACTIVE (V), .PIPE_LAT (LAT), .ADDR_W (ADDR_W)
  ) dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .filt_en_req (filt_en_req),
    .lb_wr_en    (lb_wr_en),
    .lb_addr     (lb_addr),
    .wr_bank     (wr_bank),
    .rd_bank_top (rd_bank_top),
    .rd_bank_mid (rd_bank_mid),
    .win_valid   (win_valid),
    .win_border  (win_border),
    .out_valid   (out_valid),
    .out_sel     (out_sel),
    .out_x       (out_x),
    .out_y       (out_y),
    .frame_start (frame_start),
    .state       (state)
  );

  typedef struct {
    int due;
    int x;
    int y;
    bit border;
  } res_t;

  res_t q[$];
  int   n_checks, n_pass, cyc, n_obs;
  int   m_mode, m_lines, m_bank;
  bit   m_filt, m_prev_origin, e_fs, e_win, e_border, release_pending;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    m_mode = 0; m_lines = 0; m_bank = 0; m_filt = 0; m_prev_origin = 0;
    e_fs = 0; e_win = 0; e_border = 0;
    q.delete();
  endtask

  task automatic check_all_zero();
    check("rst_lb_wr_en", 32'(lb_wr_en), 0);
    check("rst_lb_addr", 32'(lb_addr), 0);
    check("rst_wr_bank", 32'(wr_bank), 0);
    check("rst_rd_top", 32'(rd_bank_top), 0);
    check("rst_rd_mid", 32'(rd_bank_mid), 0);
    check("rst_win_valid", 32'(win_valid), 0);
    check("rst_win_border", 32'(win_border), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sel", 32'(out_sel), 0);
    check("rst_out_x", 32'(out_x), 0);
    check("rst_out_y", 32'(out_y), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_state", 32'(state), 0);
  endtask

  // One cycle of the reference: compare, then advance the expected state.
  task automatic step();
    int  px, py;
    bit  active, line_end, origin, fs, win, ev;
    res_t r;
    px = int'(pixel_x);
    py = int'(pixel_y);
    active   = (px < H) && (py < V);
    line_end = active && (px == H - 1);
    origin   = (px == 0) && (py == 0);
    fs       = origin && !m_prev_origin;

    check("lb_wr_en", 32'(lb_wr_en), 32'(active && m_mode != 0));
    if (active && m_mode != 0) check("lb_addr", 32'(lb_addr), 32'(px));
    check("wr_bank", 32'(wr_bank), 32'(m_bank));
    if (m_mode != 0) begin
      check("rd_bank_top", 32'(rd_bank_top), 32'((m_bank + 1) % 3));
      check("rd_bank_mid", 32'(rd_bank_mid), 32'((m_bank + 2) % 3));
    end
    check("state", 32'(state), 32'(m_mode));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("win_valid", 32'(win_valid), 32'(e_win));
    check("win_border", 32'(win_border), 32'(e_border));

    ev = 0;
    if (q.size() > 0) ev = (q[0].due == cyc);
    check("out_valid", 32'(out_valid), 32'(ev));
    if (out_valid === 1'b1) n_obs++;
    if (ev) begin
      r = q.pop_front();
      check("out_x", 32'(out_x), 32'(r.x));
      check("out_y", 32'(out_y), 32'(r.y));
      check("out_sel", 32'(out_sel), 32'(m_filt && !r.border));
    end else begin
      check("out_sel_idle", 32'(out_sel), 0);
    end

    win      = (m_mode == 2) && active && (px >= 1);
    e_fs     = fs;
    e_win    = win;
    e_border = win && (px == 1);
    if (win) q.push_back('{due: cyc + 1 + LAT, x: px - 1, y: py - 1, border: (px == 1)});

    if (fs) begin
      m_mode = 1; m_lines = 0; m_bank = 0; m_filt = filt_en_req;
    end else if (line_end && m_mode != 0) begin
      m_bank = (m_bank + 1) % 3;
      if (m_mode == 1) begin
        m_lines++;
        if (m_lines == 2) m_mode = 2;
      end else if (py == V - 1) begin
        m_mode = 0;
      end
    end
    m_prev_origin = origin;
    cyc++;
  endtask

  task automatic drive_pixel(input int x, input int y);
    @(negedge vga_clk);
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    filt_en_req = 1'($urandom_range(0, 1));
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 0;
    end
    #1;
    step();
  endtask

  task automatic scan_line(input int y, input int x_from);
    int htot;
    htot = H + int'($urandom_range(4, 6));
    for (int x = x_from; x < htot; x++) drive_pixel(x, y);
  endtask

  task automatic scan_frame(input int stop_line);
    for (int y = 0; y < stop_line; y++) scan_line(y, 0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; n_obs = 0;
    release_pending = 0;
    rst_n = 1'b0; pixel_x = 10'd11; pixel_y = 10'd7; filt_en_req = 1'b0;
    repeat (3) @(posedge vga_clk);
    #2;
    check_all_zero();
    model_reset();
    release_pending = 1;
    repeat (3) drive_pixel(11, 7);

    n_obs = 0; scan_frame(V_TOT); check("frame_a_count", 32'(n_obs), 32'(N_OUT));
    n_obs = 0; scan_frame(V_TOT); check("frame_b_count", 32'(n_obs), 32'(N_OUT));

    // Frame cut short after line 2; the following (0,0) is a premature start.
    n_obs = 0; scan_frame(3); check("partial_count", 32'(n_obs), 32'(H - 1));
    n_obs = 0; scan_frame(V_TOT); check("restart_count", 32'(n_obs), 32'(N_OUT));

    // Asynchronous reset mid-line at (4,2); the rest of that frame is ignored.
    n_obs = 0;
    scan_line(0, 0);
    scan_line(1, 0);
    for (int x = 0; x <= 4; x++) drive_pixel(x, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero();
    repeat (2) @(posedge vga_clk);
    model_reset();
    release_pending = 1;
    scan_line(2, 5);
    for (int y = 3; y < V_TOT; y++) scan_line(y, 0);
    check("post_reset_count", 32'(n_obs), 0);

    n_obs = 0; scan_frame(V_TOT); check("frame_e_count", 32'(n_obs), 32'(N_OUT));
    n_obs = 0; scan_frame(V_TOT); check("frame_f_count", 32'(n_obs), 32'(N_OUT));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
